// File: rtl/des_pkg.sv
// Shared DES definitions: E-expansion table, datapath typedefs, S-box group helper.
`timescale 1ns/1ps
package des_pkg;

    typedef logic [31:0] des_half_t;
    typedef logic [47:0] des_subkey_t;
    typedef logic [3:0]  des_round_t;

    // One beat held by the output (and skid) register.
    typedef struct packed {
        des_subkey_t mix;
        des_half_t   l;
        des_round_t  round;
    } des_beat_t;

    // E-table: entry i (0-based) is the DES R bit (1..32) feeding E output bit i+1.
    localparam logic [5:0] E_TABLE [48] = '{
        6'd32, 6'd1,  6'd2,  6'd3,  6'd4,  6'd5,
        6'd4,  6'd5,  6'd6,  6'd7,  6'd8,  6'd9,
        6'd8,  6'd9,  6'd10, 6'd11, 6'd12, 6'd13,
        6'd12, 6'd13, 6'd14, 6'd15, 6'd16, 6'd17,
        6'd16, 6'd17, 6'd18, 6'd19, 6'd20, 6'd21,
        6'd20, 6'd21, 6'd22, 6'd23, 6'd24, 6'd25,
        6'd24, 6'd25, 6'd26, 6'd27, 6'd28, 6'd29,
        6'd28, 6'd29, 6'd30, 6'd31, 6'd32, 6'd1
    };

    // 6-bit group g (1..8) of a subkey-wide word; group 1 is the MSBs and feeds S1.
    function automatic logic [5:0] des_group(input des_subkey_t k, input logic [3:0] g);
        des_subkey_t sh;
        sh = k >> (48 - 6 * int'(g));
        return sh[5:0];
    endfunction

endpackage

// File: rtl/des_expand.sv
// Combinational DES E-expansion, 32 -> 48 bits, DES MSB-first bit numbering.
`timescale 1ns/1ps
module des_expand
    import des_pkg::*;
(
    input  des_half_t   r,
    output des_subkey_t e
);

    // Each E output bit is a pure wire from the R bit named in E_TABLE.
    for (genvar i = 0; i < 48; i++) begin : g_e
        localparam int SRC = 32 - int'(E_TABLE[i]);
        assign e[47 - i] = r[SRC];
    end

endmodule

// File: rtl/des_expand_mix.sv
// Registered E-expansion + subkey XOR stage with valid/ready handshake.
// Optional skid buffer enabled by macro DES_EXPAND_MIX_SKID_EN.
// Handshake: a beat moves when valid && ready on the same rising edge; valid
// never drops and data never changes while waiting for ready.
`timescale 1ns/1ps
module des_expand_mix
    import des_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_r,
    input  logic [31:0] in_l,
    input  logic [47:0] in_key,
    input  logic [3:0]  in_round,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [47:0] out_mix,
    output logic [31:0] out_l,
    output logic [3:0]  out_round
);

    des_subkey_t e_w;
    des_beat_t   in_beat;
    des_beat_t   out_q, out_d;
    logic        out_valid_q, out_valid_d;
    logic        accept;
    logic        consume;

    des_expand u_expand (
        .r (in_r),
        .e (e_w)
    );

    assign in_beat = '{mix: e_w ^ in_key, l: in_l, round: in_round};
    assign consume = out_valid_q && out_ready;

`ifdef DES_EXPAND_MIX_SKID_EN
    des_beat_t skid_q, skid_d;
    logic      skid_full_q, skid_full_d;
    logic      in_ready_q, in_ready_d;

    assign accept   = in_valid && in_ready_q;
    assign in_ready = in_ready_q;

    // Output/skid steering: skid always drains into the output before any newer beat.
    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        skid_d      = skid_q;
        skid_full_d = skid_full_q;
        if (!out_valid_q || consume) begin
            if (skid_full_q) begin
                out_d       = skid_q;
                out_valid_d = 1'b1;
                skid_full_d = accept;
                if (accept) begin
                    skid_d = in_beat;
                end
            end else if (accept) begin
                out_d       = in_beat;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d      = in_beat;
            skid_full_d = 1'b1;
        end
        in_ready_d = !skid_full_d;
    end

    // Skid register and registered ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_q      <= '0;
            skid_full_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            skid_q      <= skid_d;
            skid_full_q <= skid_full_d;
            in_ready_q  <= in_ready_d;
        end
    end
`else
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Single output register: load on accept, clear valid when consumed with nothing new.
    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (accept) begin
            out_d       = in_beat;
            out_valid_d = 1'b1;
        end else if (consume) begin
            out_valid_d = 1'b0;
        end
    end
`endif

    // Output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_mix   = out_q.mix;
    assign out_l     = out_q.l;
    assign out_round = out_q.round;

endmodule
